// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
// Sequencer for an up/down/load counter that has no count enable. On an
// accepted start it loads the low limit, counts up to the high limit and
// back down, repeats that triangle for the programmed number of passes, then
// parks the counter at the low limit and pulses done. While idle it keeps the
// counter still by reloading the park value every cycle.
//
// Ports
//   clk, reset_n       : rising-edge clock, asynchronous active-low reset
//   start              : sweep request, sampled only in IDLE
//   abort              : sweep cancel, sampled only in LOAD/UP/DOWN
//   lo_limit, hi_limit : sweep limits, captured with an accepted start
//   num_passes         : number of up+down passes, captured with start
//   counter_value      : current counter output
//   load_en, up_down,
//   counter_in         : counter controls (combinational)
//   busy               : high in LOAD, UP and DOWN
//   done               : one-cycle pulse in DONE
//   err                : registered one-cycle pulse for a rejected start
//   passes_left        : passes remaining, including the current one
module counter_sweep_ctrl #(
  parameter int CNT_WIDTH  = 3,
  parameter int PASS_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  lo_limit,
  input  logic [CNT_WIDTH-1:0]  hi_limit,
  input  logic [PASS_WIDTH-1:0] num_passes,
  input  logic [CNT_WIDTH-1:0]  counter_value,
  output logic                  load_en,
  output logic                  up_down,
  output logic [CNT_WIDTH-1:0]  counter_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [PASS_WIDTH-1:0] passes_left
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [PASS_WIDTH-1:0] PASS_ZERO = {PASS_WIDTH{1'b0}};
  localparam logic [PASS_WIDTH-1:0] PASS_ONE  = {{(PASS_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q,  state_d;
  logic [CNT_WIDTH-1:0]    lo_q,     lo_d;
  logic [CNT_WIDTH-1:0]    hi_q,     hi_d;
  logic [CNT_WIDTH-1:0]    park_q,   park_d;
  logic [PASS_WIDTH-1:0]   passes_q, passes_d;
  logic                    err_q,    err_d;

  logic cfg_valid_s;

  // A start is only accepted with a non-empty range and at least one pass.
  assign cfg_valid_s = (lo_limit < hi_limit) && (num_passes != PASS_ZERO);

  // Next-state, register updates and counter control outputs.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    park_d     = park_q;
    passes_d   = passes_q;
    err_d      = 1'b0;
    load_en    = 1'b0;
    up_down    = 1'b0;
    counter_in = lo_q;

    case (state_q)
      ST_IDLE: begin
        // Continuous reload is the only way to hold an enable-less counter.
        load_en    = 1'b1;
        counter_in = park_q;
        if (start) begin
          if (cfg_valid_s) begin
            lo_d     = lo_limit;
            hi_d     = hi_limit;
            park_d   = lo_limit;
            passes_d = num_passes;
            state_d  = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        load_en    = 1'b1;
        counter_in = lo_q;
        if (abort) begin
          passes_d = PASS_ZERO;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_UP;
        end
      end

      ST_UP: begin
        // Turn around in the cycle that shows hi_q so the counter never
        // steps past it.
        if (counter_value != hi_q) begin
          up_down = 1'b1;
        end else begin
          up_down = 1'b0;
        end
        if (abort) begin
          passes_d = PASS_ZERO;
          state_d  = ST_IDLE;
        end else if (counter_value == hi_q) begin
          state_d = ST_DOWN;
        end else begin
          state_d = ST_UP;
        end
      end

      ST_DOWN: begin
        if (counter_value == lo_q) begin
          if (passes_q > PASS_ONE) begin
            up_down = 1'b1;
          end else begin
            // Last pass: reload lo_q so the counter stays parked.
            load_en    = 1'b1;
            counter_in = lo_q;
          end
        end else begin
          up_down = 1'b0;
        end
        if (abort) begin
          passes_d = PASS_ZERO;
          state_d  = ST_IDLE;
        end else if (counter_value == lo_q) begin
          if (passes_q > PASS_ONE) begin
            passes_d = passes_q - PASS_ONE;
            state_d  = ST_UP;
          end else begin
            passes_d = PASS_ZERO;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_DOWN;
        end
      end

      ST_DONE: begin
        load_en    = 1'b1;
        counter_in = lo_q;
        state_d    = ST_IDLE;
      end

      default: begin
        load_en    = 1'b1;
        counter_in = park_q;
        passes_d   = PASS_ZERO;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and captured configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      lo_q     <= CNT_ZERO;
      hi_q     <= CNT_ZERO;
      park_q   <= CNT_ZERO;
      passes_q <= PASS_ZERO;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      park_q   <= park_d;
      passes_q <= passes_d;
      err_q    <= err_d;
    end
  end

  assign busy        = (state_q == ST_LOAD) || (state_q == ST_UP) || (state_q == ST_DOWN);
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;
  assign passes_left = passes_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
module tb_counter_sweep_ctrl;

  localparam int CW = 3;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] lo_limit;
  logic [CW-1:0] hi_limit;
  logic [PW-1:0] num_passes;
  logic [CW-1:0] counter_value;
  logic          load_en;
  logic          up_down;
  logic [CW-1:0] counter_in;
  logic          busy;
  logic          done;
  logic          err;
  logic [PW-1:0] passes_left;

  int n_checks = 0;
  int n_pass   = 0;
  int park_m   = 0;

  counter_sweep_ctrl #(.CNT_WIDTH(CW), .PASS_WIDTH(PW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .lo_limit      (lo_limit),
    .hi_limit      (hi_limit),
    .num_passes    (num_passes),
    .counter_value (counter_value),
    .load_en       (load_en),
    .up_down       (up_down),
    .counter_in    (counter_in),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .passes_left   (passes_left)
  );

  always #5 clk = ~clk;

  // The controlled counter: load, else count up/down modulo 2^CW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      counter_value <= 3'd0;
    else if (load_en)  counter_value <= counter_in;
    else if (up_down)  counter_value <= counter_value + 3'd1;
    else               counter_value <= counter_value - 3'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counter value at position pos of a sweep, pos 0 being the initial lo.
  function automatic int seqv(input int lo, input int hi, input int pos);
    int d, r;
    d = hi - lo;
    if (pos == 0) return lo;
    r = (pos - 1) % (2 * d) + 1;
    if (r <= d) return lo + r;
    return hi - (r - d);
  endfunction

  // Passes remaining while the counter shows sweep position pos.
  function automatic int exp_passes(input int lo, input int hi, input int n, input int pos);
    int d, p;
    d = hi - lo;
    p = (pos == 0) ? 1 : (pos - 1) / (2 * d) + 1;
    return n - p + 1;
  endfunction

  task automatic check_idle(input string tag, input int park);
    chk({tag, ".load_en"}, load_en, 1);
    chk({tag, ".counter_in"}, counter_in, park);
    chk({tag, ".cnt"}, counter_value, park);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".load_en"}, load_en, 1);
    chk({tag, ".counter_in"}, counter_in, 0);
    chk({tag, ".up_down"}, up_down, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".passes"}, passes_left, 0);
    chk({tag, ".cnt"}, counter_value, 0);
  endtask

  // One sweep from IDLE; abort_j / reset_j select the busy sample (-1 = none).
  task automatic run_sweep(input int lo, input int hi, input int n,
                           input int abort_j, input int reset_j);
    int len, cv;
    len = 1 + 2 * n * (hi - lo);
    start = 1'b1;
    abort = 1'b0;
    lo_limit = lo[CW-1:0];
    hi_limit = hi[CW-1:0];
    num_passes = n[PW-1:0];
    step();
    for (int j = 0; j <= len; j++) begin
      cv = (j == 0) ? park_m : seqv(lo, hi, j - 1);
      chk("sweep.cnt", counter_value, cv);
      chk("sweep.busy", busy, 1);
      chk("sweep.done", done, 0);
      chk("sweep.passes", passes_left, exp_passes(lo, hi, n, (j == 0) ? 0 : j - 1));
      chk("sweep.err", err, 0);
      // start and new limits while busy must be ignored
      start = 1'($urandom_range(0, 1));
      lo_limit = CW'($urandom);
      hi_limit = CW'($urandom);
      num_passes = PW'($urandom);
      if (j == reset_j) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        start = 1'b0;
        #2;
        reset_n = 1'b1;
        park_m = 0;
        step();
        check_idle("post_rst", 0);
        return;
      end
      if (j == abort_j) begin
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.passes", passes_left, 0);
        chk("abort.cnt", counter_value, (j < len) ? seqv(lo, hi, j) : lo);
        step();
        check_idle("abort_park", lo);
        park_m = lo;
        return;
      end
      step();
    end
    // DONE cycle; abort here must be ignored
    start = 1'b0;
    chk("done.pulse", done, 1);
    chk("done.busy", busy, 0);
    chk("done.cnt", counter_value, lo);
    chk("done.passes", passes_left, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("after_done", lo);
    park_m = lo;
  endtask

  task automatic reject(input int lo, input int hi, input int n);
    start = 1'b1;
    lo_limit = lo[CW-1:0];
    hi_limit = hi[CW-1:0];
    num_passes = n[PW-1:0];
    step();
    start = 1'b0;
    chk("reject.err", err, 1);
    chk("reject.busy", busy, 0);
    chk("reject.cnt", counter_value, park_m);
    step();
    chk("reject.err_clr", err, 0);
    check_idle("reject_idle", park_m);
  endtask

  initial begin
    int lo, hi, n, len, aj;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    lo_limit = 3'd0;
    hi_limit = 3'd0;
    num_passes = 4'd0;
    #3;
    check_reset_outputs("reset");
    #9;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      abort = 1'($urandom_range(0, 1));
      step();
      check_idle("idle", 0);
      chk("idle.err", err, 0);
    end
    abort = 1'b0;

    run_sweep(1, 3, 1, -1, -1);
    run_sweep(0, 7, 2, -1, -1);
    reject(3, 3, 2);
    reject(2, 5, 0);
    reject(6, 1, 1);
    run_sweep(2, 6, 1, 4, -1);
    run_sweep(1, 5, 2, -1, 7);

    for (int k = 0; k < 10; k++) begin
      lo = $urandom_range(0, 6);
      hi = $urandom_range(lo + 1, 7);
      n = $urandom_range(1, 3);
      len = 1 + 2 * n * (hi - lo);
      aj = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
      run_sweep(lo, hi, n, aj, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
